// File: rtl/mult_seq_32bit.sv
// mult_seq_32bit: unsigned shift-add multiplier, one product per WIDTH iterations via start/busy/done.
module mult_seq_32bit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       sum;
  logic                 accept, run, last;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      product_q <= product_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN) : IDLE;
  end
  // carry lands in hi's MSB after the shift, so it never needs its own flop
  always_comb begin
    accept    = (state_q == IDLE) && start;
    run       = (state_q == RUN);
    last      = (cnt_q == CW'(1));
    sum       = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};
    mcand_d   = accept ? a : mcand_q;
    hi_d      = accept ? '0 : run ? sum[WIDTH:1] : hi_q;
    lo_d      = accept ? b  : run ? {sum[0], lo_q[WIDTH-1:1]} : lo_q;
    cnt_d     = accept ? CW'(WIDTH) : run ? cnt_q - CW'(1) : cnt_q;
    product_d = (run && last) ? {sum[WIDTH:1], sum[0], lo_q[WIDTH-1:1]} : product_q;
  end
  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    product = product_q;
  end
endmodule

// File: tb/tb_mult_seq_32bit.sv
// tb_mult_seq_32bit: directed checks of the sequential multiplier handshake, results and reset.
module tb_mult_seq_32bit;
  logic        clk = 0, rst_n = 0, start = 0, busy, done;
  logic [31:0] a = 0, b = 0;
  logic [63:0] product;
  int checks = 0, errors = 0;
  mult_seq_32bit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // called on a negedge in IDLE; returns on the negedge after done falls
  task automatic do_op(input string tag, input logic [31:0] aa, input logic [31:0] bb, input logic [63:0] exp);
    int n;
    a = aa; b = bb; start = 1;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk); n++;
      a = $urandom; b = $urandom;
    end
    check({tag, "_lat"}, 64'(n), 64'd32);
    check({tag, "_prod"}, product, exp);
    check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    @(negedge clk);
    check({tag, "_done_fall"}, {63'd0, done}, 64'd0);
    check({tag, "_hold"}, product, exp);
  endtask
  initial begin
    int n;
    logic held;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_prod", product, 64'd0);
    rst_n = 1;
    @(negedge clk);
    do_op("basic", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    do_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    do_op("msb", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    do_op("zero_a", 32'd0, 32'hDEAD_BEEF, 64'd0);
    do_op("zero_b", 32'h1234_5678, 32'd0, 64'd0);
    // start re-asserted mid-run with churning operands must be ignored
    a = 7; b = 6; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    start = 1; a = 9; b = 9;
    n = 4;
    while (!done && n < 40) begin
      @(negedge clk); n++;
      a = $urandom; b = $urandom;
    end
    check("ign_lat", 64'(n), 64'd32);
    check("ign_prod", product, 64'd42);
    start = 0;
    @(negedge clk);
    check("ign_idle_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("ign_no_queue", {63'd0, busy}, 64'd0);
    // reset seen at E10 of a run
    a = 32'd100; b = 32'd200; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_prod", product, 64'd0);
    rst_n = 1;
    do_op("post_rst", 32'd100, 32'd200, 64'd20000);
    rst_n = 0; start = 1; a = 5; b = 5;
    @(negedge clk);
    check("rst_wins_busy", {63'd0, busy}, 64'd0);
    rst_n = 1; start = 0;
    @(negedge clk);
    check("rst_wins_idle", {63'd0, busy}, 64'd0);
    check("rst_wins_prod", product, 64'd0);
    // back-to-back with start held high
    a = 32'd10; b = 32'd10; start = 1;
    @(negedge clk);
    a = 32'h0000_FFFF; b = 32'h0001_0001;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("b2b1_lat", 64'(n), 64'd32);
    check("b2b1_prod", product, 64'd100);
    @(negedge clk); n++;
    check("b2b_gap_busy", {63'd0, busy}, 64'd0);
    check("b2b_gap_done", {63'd0, done}, 64'd0);
    @(negedge clk); n++;
    check("b2b2_busy", {63'd0, busy}, 64'd1);
    held = 1;
    while (!done && n < 80) begin
      if (product !== 64'd100) held = 0;
      @(negedge clk); n++;
    end
    check("b2b_hold", {63'd0, held}, 64'd1);
    check("b2b2_lat", 64'(n), 64'd66);
    check("b2b2_prod", product, 64'h0000_0000_FFFF_FFFF);
    start = 0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule

// File: doc/mult_seq_32bit.md
# mult_seq_32bit

Unsigned sequential shift-add multiplier for the ALU datapath. Takes two `WIDTH`-bit operands from the operand stage and returns a `2*WIDTH`-bit product after a fixed `WIDTH`-cycle iteration. The product feeds the ALU result mux alongside the combinational bitwise units (AND/OR/XOR). The block accepts one operation at a time through a start/busy/done handshake.

## Interface

Parameters:
- `WIDTH`, default 32: operand width in bits. The product is `2*WIDTH` bits.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst_n`, input, 1: **synchronous, active-low** reset, sampled on the rising edge of `clk`.
- `start`, input, 1: request a multiply. Honoured only in IDLE.
- `a`, input, `WIDTH`: multiplicand. Sampled on the accepting edge only.
- `b`, input, `WIDTH`: multiplier. Sampled on the accepting edge only.
- `busy`, output, 1: high while an operation is iterating (RUN).
- `done`, output, 1: one-cycle pulse; `product` is valid from this cycle.
- `product`, output, `2*WIDTH`: result. Held stable until the next result is written.

## Operation

**States.** IDLE, RUN, DONE. Encoding is free.

**Transitions.**
- IDLE → RUN when `start`=1 at an edge (the accepting edge).
- RUN → RUN while the iteration counter is nonzero after decrement.
- RUN → DONE on the edge that performs iteration `WIDTH`.
- DONE → IDLE unconditionally on the next edge.

**Accept.** On the accepting edge:
- Latch `a` into the multiplicand register.
- Load the working register: `hi`=0, `lo`=`b`, `carry`=0.
- Set the counter to `WIDTH`.

**Iteration (one per RUN edge).**
- If `lo[0]`=1, `{carry,hi}` = `hi + mcand`, computed `WIDTH+1` bits wide. Otherwise `{carry,hi}` = `{0,hi}`.
- Then logical right shift of `{carry,hi,lo}` by 1.
- Decrement the counter.
- No overflow is possible: the final `{hi,lo}` is the exact `2*WIDTH`-bit unsigned product.

**Result.** On the RUN→DONE edge, `product` ← final `{hi,lo}`. `product` is a separate hold register; intermediate working values never appear on it.

**Outputs by state.**
- `busy` = 1 exactly in RUN.
- `done` = 1 exactly in DONE.

**Ignored inputs.**
- `start` in RUN or DONE: no effect, no queuing.
- Changes to `a`/`b` after the accepting edge: no effect.

**Reset.** Whenever `rst_n`=0 at an edge, regardless of state, including mid-RUN:
- State → IDLE.
- `busy`=0, `done`=0, `product`=0.
- Counter, working register and multiplicand register → 0.

Reset has priority over `start`.

## Timing

- Accepting edge E0: `busy` rises after E0.
- Iterations at edges E1..E`WIDTH`.
- After E`WIDTH`: `busy`=0, `done`=1, `product` valid.
- After E`WIDTH+1`: `done`=0, state IDLE, `product` unchanged.
- Latency from accepting edge to `done` high: `WIDTH` cycles (32 for the default).
- Throughput: one operation per `WIDTH+2` cycles, since `start` is first honoured again at E`WIDTH+2`.
- `start` held continuously high produces back-to-back operations, each accepted on the first edge in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Basic multiply.** Reset, then `a`=3, `b`=5, `start` pulsed at E0 → `busy`=1 for cycles after E1..E31, `done`=1 only after E32, `product`=0x0000_0000_0000_000F.
- **Max operands.** `a`=`b`=0xFFFF_FFFF → `product`=0xFFFF_FFFE_0000_0001, which exercises the carry bit every iteration. Also `a`=0x8000_0000, `b`=2 → 0x0000_0001_0000_0000.
- **Zero operands.** `a`=0, `b`=0xDEAD_BEEF, then `a`=0x1234_5678, `b`=0 → both give `product`=0, with `done` timing identical to the basic case.
- **Ignored inputs.** Start `a`=7, `b`=6; at E5 assert `start` with `a`=9, `b`=9 and change `a`/`b` every cycle → single `done` after E32, `product`=42. No second operation starts until IDLE.
- **Reset mid-operation.** `rst_n`=0 at E10 of a run → after E10, `busy`=0, `done`=0, `product`=0. With `rst_n` back to 1 and `start` asserted → normal run with correct result. `start` and `rst_n`=0 together → reset wins, nothing accepted.
- **Back-to-back and hold.** `start` held high with operand pairs (10,10) then (0xFFFF, 0x10001) → `done` after E32 with 100, next accept at E34, `done` after E66 with 0xFFFF_FFFF. `product` stays 100 throughout cycles E33..E65.
